// File: rtl/local_eject_reassembler_if.sv
// Bundle between the Local ejection port, the reassembler and the core.
// The reassembler sits on the slave side; the router/core environment drives the master side.
interface local_eject_reassembler_if #(
  parameter int WIDTH_DATA = 16
);
  localparam int WIDTH_PORT = 24 + WIDTH_DATA;

  logic                    flitValid;
  logic [WIDTH_PORT-1:0]   doutLocal;
  logic                    pktValid;
  logic                    pktReady;
  logic [5:0]              pktId;
  logic [7:0]              pktTime;
  logic [4*WIDTH_DATA-1:0] pktData;
  logic                    dropErr;
  logic                    dupErr;
  logic [7:0]              dropCount;

  modport master (
    output flitValid, doutLocal, pktReady,
    input  pktValid, pktId, pktTime, pktData, dropErr, dupErr, dropCount
  );

  modport slave (
    input  flitValid, doutLocal, pktReady,
    output pktValid, pktId, pktTime, pktData, dropErr, dupErr, dropCount
  );
endinterface

// File: rtl/local_eject_reassembler.sv
// Collects out-of-order flits from the Local output port into per-PKTID slots
// and hands each complete 4-flit packet to the core through a one-deep output stage.
module local_eject_reassembler #(
  parameter int         WIDTH_DATA = 16,
  parameter int         NUM_SLOTS  = 4,
  parameter logic [3:0] MY_X       = 4'd0,
  parameter logic [3:0] MY_Y       = 4'd0
) (
  input logic                     clk,
  input logic                     reset,
  local_eject_reassembler_if.slave bus
);
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic [5:0]            inPktId;
  logic [1:0]            inFlitId;
  logic [7:0]            inTime;
  logic [3:0]            inPosX;
  logic [3:0]            inPosY;
  logic [WIDTH_DATA-1:0] inData;
  logic [3:0]            flitOneHot;

  assign {inPktId, inFlitId, inTime, inPosX, inPosY, inData} = bus.doutLocal;
  assign flitOneHot = 4'b0001 << inFlitId;

  logic [NUM_SLOTS-1:0]                   slotValid;
  logic [NUM_SLOTS-1:0][5:0]              slotId;
  logic [NUM_SLOTS-1:0][3:0]              slotMask;
  logic [NUM_SLOTS-1:0][7:0]              slotTime;
  logic [NUM_SLOTS-1:0][4*WIDTH_DATA-1:0] slotData;
  logic [NUM_SLOTS-1:0]                   slotComplete;
  logic [NUM_SLOTS-1:0]                   slotHit;
  logic [NUM_SLOTS-1:0]                   slotFree;

  logic [IDX_W-1:0] hitIdx;
  logic [IDX_W-1:0] freeIdx;
  logic [IDX_W-1:0] doneIdx;
  logic             posOk;
  logic             flitOk;
  logic             dupFlit;
  logic             dropFlit;
  logic             writeEn;
  logic             allocEn;
  logic             loadEn;

  logic                    pktValidReg;
  logic [5:0]              pktIdReg;
  logic [7:0]              pktTimeReg;
  logic [4*WIDTH_DATA-1:0] pktDataReg;
  logic                    dropErrReg;
  logic                    dupErrReg;
  logic [7:0]              dropCountReg;

  // Complete slots are excluded from matching so a recycled PKTID opens a fresh slot.
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : gSlot
      logic                  validReg;
      logic [5:0]            idReg;
      logic [3:0]            maskReg;
      logic [7:0]            timeReg;
      logic [WIDTH_DATA-1:0] dataReg [4];
      logic                  allocHere;
      logic                  writeHere;

      assign allocHere = allocEn && (freeIdx == IDX_W'(gi));
      assign writeHere = writeEn && (hitIdx == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          validReg <= 1'b0;
          maskReg  <= 4'h0;
        end else begin
          if (allocHere) begin
            validReg <= 1'b1;
            idReg    <= inPktId;
            maskReg  <= flitOneHot;
          end else if (writeHere) begin
            maskReg <= maskReg | flitOneHot;
          end
          if (loadEn && (doneIdx == IDX_W'(gi))) begin
            validReg <= 1'b0;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (allocHere || writeHere) begin
          dataReg[inFlitId] <= inData;
          if (inFlitId == 2'd0) begin
            timeReg <= inTime;
          end
        end
      end

      assign slotValid[gi]    = validReg;
      assign slotId[gi]       = idReg;
      assign slotMask[gi]     = maskReg;
      assign slotTime[gi]     = timeReg;
      assign slotData[gi]     = {dataReg[3], dataReg[2], dataReg[1], dataReg[0]};
      assign slotComplete[gi] = validReg && (maskReg == 4'hF);
      assign slotHit[gi]      = validReg && (maskReg != 4'hF) && (idReg == inPktId);
      assign slotFree[gi]     = !validReg;
    end
  endgenerate

  // Descending scan leaves the lowest matching index in each selector.
  always_comb begin
    hitIdx  = '0;
    freeIdx = '0;
    doneIdx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slotHit[i])      hitIdx  = IDX_W'(i);
      if (slotFree[i])     freeIdx = IDX_W'(i);
      if (slotComplete[i]) doneIdx = IDX_W'(i);
    end
  end

  always_comb begin
    posOk    = (inPosX == MY_X) && (inPosY == MY_Y);
    flitOk   = bus.flitValid && posOk;
    dupFlit  = flitOk && (|slotHit) && slotMask[hitIdx][inFlitId];
    writeEn  = flitOk && (|slotHit) && !slotMask[hitIdx][inFlitId];
    allocEn  = flitOk && !(|slotHit) && (|slotFree);
    dropFlit = bus.flitValid && (!posOk || (!(|slotHit) && !(|slotFree)));
    loadEn   = (!pktValidReg || bus.pktReady) && (|slotComplete);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pktValidReg  <= 1'b0;
      pktIdReg     <= 6'd0;
      pktTimeReg   <= 8'd0;
      pktDataReg   <= '0;
      dropErrReg   <= 1'b0;
      dupErrReg    <= 1'b0;
      dropCountReg <= 8'd0;
    end else begin
      if (loadEn) begin
        pktValidReg <= 1'b1;
        pktIdReg    <= slotId[doneIdx];
        pktTimeReg  <= slotTime[doneIdx];
        pktDataReg  <= slotData[doneIdx];
      end else if (bus.pktReady) begin
        pktValidReg <= 1'b0;
      end
      dropErrReg <= dropFlit;
      dupErrReg  <= dupFlit;
      if (dropFlit && (dropCountReg != 8'hFF)) begin
        dropCountReg <= dropCountReg + 8'd1;
      end
    end
  end

  assign bus.pktValid  = pktValidReg;
  assign bus.pktId     = pktIdReg;
  assign bus.pktTime   = pktTimeReg;
  assign bus.pktData   = pktDataReg;
  assign bus.dropErr   = dropErrReg;
  assign bus.dupErr    = dupErrReg;
  assign bus.dropCount = dropCountReg;
endmodule

// File: tb/tb_local_eject_reassembler.sv
// Directed bench for local_eject_reassembler: stimulus pushes expected packets,
// a negedge monitor pops and compares them on every handshake.
module tb_local_eject_reassembler;
  logic clk;
  logic reset;

  local_eject_reassembler_if #(.WIDTH_DATA(16)) bus();

  local_eject_reassembler #(
    .WIDTH_DATA(16),
    .NUM_SLOTS (4),
    .MY_X      (4'd0),
    .MY_Y      (4'd0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [5:0]  id;
    logic [7:0]  tm;
    logic [63:0] data;
  } pkt_t;

  pkt_t expQ[$];
  int   errors  = 0;
  int   checks  = 0;
  int   hsCount = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Time field encodes {pktId, flitId} so the expected pktTime is {id, 2'b00}.
  task automatic sendFlit(input logic [5:0] id, input logic [1:0] fid, input logic [3:0] px,
                          input logic [3:0] py, input logic [15:0] d);
    bus.flitValid = 1'b1;
    bus.doutLocal = {id, fid, {id, fid}, px, py, d};
    tick();
    bus.flitValid = 1'b0;
  endtask

  task automatic flit(input logic [5:0] id, input logic [1:0] fid, input logic [15:0] d);
    sendFlit(id, fid, 4'd0, 4'd0, d);
  endtask

  task automatic expect_pkt(input logic [5:0] id, input logic [63:0] data);
    pkt_t p;
    p.id   = id;
    p.tm   = {id, 2'b00};
    p.data = data;
    expQ.push_back(p);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Monitor: pops on handshake, and checks that a held packet does not change.
  logic        heldPrev = 1'b0;
  logic [5:0]  prevId;
  logic [7:0]  prevTm;
  logic [63:0] prevData;
  always @(negedge clk) begin
    if (reset) begin
      heldPrev = 1'b0;
    end else begin
      if (heldPrev) begin
        chk("hold_valid", {63'd0, bus.pktValid}, 64'd1);
        chk("hold_id", {58'd0, bus.pktId}, {58'd0, prevId});
        chk("hold_time", {56'd0, bus.pktTime}, {56'd0, prevTm});
        chk("hold_data", bus.pktData, prevData);
      end
      if (bus.pktValid && bus.pktReady) begin
        hsCount++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pkt: got id %0h data %0h expected none", bus.pktId, bus.pktData);
        end else begin
          pkt_t e;
          e = expQ.pop_front();
          chk("pkt_id", {58'd0, bus.pktId}, {58'd0, e.id});
          chk("pkt_time", {56'd0, bus.pktTime}, {56'd0, e.tm});
          chk("pkt_data", bus.pktData, e.data);
        end
      end
      heldPrev = bus.pktValid && !bus.pktReady;
      prevId   = bus.pktId;
      prevTm   = bus.pktTime;
      prevData = bus.pktData;
    end
  end

  initial begin
    int base;
    reset         = 1'b1;
    bus.flitValid = 1'b0;
    bus.doutLocal = '0;
    bus.pktReady  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", {63'd0, bus.pktValid}, 64'd0);
    chk("rst_id", {58'd0, bus.pktId}, 64'd0);
    chk("rst_time", {56'd0, bus.pktTime}, 64'd0);
    chk("rst_data", bus.pktData, 64'd0);
    chk("rst_dropErr", {63'd0, bus.dropErr}, 64'd0);
    chk("rst_dupErr", {63'd0, bus.dupErr}, 64'd0);
    chk("rst_dropCount", {56'd0, bus.dropCount}, 64'd0);

    // In-order packet with latency check.
    expect_pkt(6'd5, 64'hDDDD_CCCC_BBBB_AAAA);
    flit(6'd5, 2'd0, 16'hAAAA);
    flit(6'd5, 2'd1, 16'hBBBB);
    flit(6'd5, 2'd2, 16'hCCCC);
    flit(6'd5, 2'd3, 16'hDDDD);
    chk("lat_not_yet", {63'd0, bus.pktValid}, 64'd0);
    tick();
    chk("lat_valid", {63'd0, bus.pktValid}, 64'd1);
    chk("lat_id", {58'd0, bus.pktId}, 64'd5);
    chk("inorder_dropCount", {56'd0, bus.dropCount}, 64'd0);
    tick();

    // Out-of-order interleave: pkt 2 completes first.
    doReset();
    flit(6'd1, 2'd2, 16'h1002);
    flit(6'd1, 2'd0, 16'h1000);
    flit(6'd2, 2'd3, 16'h2003);
    flit(6'd2, 2'd1, 16'h2001);
    flit(6'd2, 2'd0, 16'h2000);
    expect_pkt(6'd2, 64'h2003_2002_2001_2000);
    flit(6'd2, 2'd2, 16'h2002);
    expect_pkt(6'd1, 64'h1003_1002_1001_1000);
    flit(6'd1, 2'd3, 16'h1003);
    flit(6'd1, 2'd1, 16'h1001);
    repeat (4) tick();

    // Overflow: fifth concurrent PKTID is dropped.
    doReset();
    for (int i = 1; i <= 4; i++) begin
      flit(6'(i), 2'd0, 16'h0F00);
      chk("ovf_no_drop", {63'd0, bus.dropErr}, 64'd0);
    end
    flit(6'd5, 2'd0, 16'h0F05);
    chk("ovf_dropErr", {63'd0, bus.dropErr}, 64'd1);
    chk("ovf_dropCount", {56'd0, bus.dropCount}, 64'd1);
    tick();
    chk("ovf_dropErr_pulse", {63'd0, bus.dropErr}, 64'd0);
    chk("ovf_dropCount_hold", {56'd0, bus.dropCount}, 64'd1);

    // Backpressure: P held in stage, then Q (slot 0) drains before R (slot 1).
    doReset();
    bus.pktReady = 1'b0;
    expect_pkt(6'd20, 64'h2403_2402_2401_2400);
    expect_pkt(6'd21, 64'h2103_2102_2101_2100);
    expect_pkt(6'd22, 64'h2203_2202_2201_2200);
    flit(6'd21, 2'd0, 16'h2100);
    flit(6'd22, 2'd0, 16'h2200);
    for (int f = 0; f < 4; f++) flit(6'd20, 2'(f), 16'h2400 + 16'(f));
    for (int f = 1; f < 4; f++) flit(6'd22, 2'(f), 16'h2200 + 16'(f));
    for (int f = 1; f < 4; f++) flit(6'd21, 2'(f), 16'h2100 + 16'(f));
    repeat (2) tick();
    chk("bp_held_id", {58'd0, bus.pktId}, 64'd20);
    base = hsCount;
    bus.pktReady = 1'b1;
    repeat (3) tick();
    chk("bp_three_handshakes", 64'(hsCount - base), 64'd3);
    chk("bp_drained", {63'd0, bus.pktValid}, 64'd0);

    // Misrouted flit and duplicate flit.
    doReset();
    sendFlit(6'd40, 2'd0, 4'd3, 4'd0, 16'hBEEF);
    chk("misroute_dropErr", {63'd0, bus.dropErr}, 64'd1);
    chk("misroute_dropCount", {56'd0, bus.dropCount}, 64'd1);
    flit(6'd30, 2'd0, 16'h3000);
    flit(6'd30, 2'd1, 16'h3001);
    chk("first_f1_no_dup", {63'd0, bus.dupErr}, 64'd0);
    flit(6'd30, 2'd1, 16'hBAD1);
    chk("dupErr", {63'd0, bus.dupErr}, 64'd1);
    chk("dup_no_drop", {63'd0, bus.dropErr}, 64'd0);
    flit(6'd30, 2'd2, 16'h3002);
    chk("dupErr_pulse", {63'd0, bus.dupErr}, 64'd0);
    expect_pkt(6'd30, 64'h3003_3002_3001_3000);
    flit(6'd30, 2'd3, 16'h3003);
    repeat (3) tick();

    // Reset mid-packet: the pre-reset flits must not reappear.
    doReset();
    flit(6'd7, 2'd0, 16'hEEE0);
    flit(6'd7, 2'd1, 16'hEEE1);
    doReset();
    chk("midrst_valid", {63'd0, bus.pktValid}, 64'd0);
    flit(6'd7, 2'd2, 16'h7002);
    flit(6'd7, 2'd3, 16'h7003);
    repeat (4) tick();
    chk("midrst_no_pkt", {63'd0, bus.pktValid}, 64'd0);
    expect_pkt(6'd7, 64'h7003_7002_7001_7000);
    flit(6'd7, 2'd0, 16'h7000);
    flit(6'd7, 2'd1, 16'h7001);

    for (int i = 0; i < 50 && expQ.size() != 0; i++) tick();
    chk("queue_drained", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
